// File: rtl/pixel_write_sink_pkg.sv
// Shared screen geometry, framebuffer widths and sink state encodings.
package pixel_write_sink_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;
  localparam int unsigned FB_WORDS = SCREEN_W * SCREEN_H;

  localparam int unsigned X_W      = 8;
  localparam int unsigned Y_W      = 7;
  localparam int unsigned ADDR_W   = 15;
  localparam int unsigned COLOUR_W = 18;

  typedef enum logic [1:0] {
    StIdle,
    StDrain,
    StClear,
    StDone
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]   addr;
    logic [COLOUR_W-1:0] colour;
  } pixel_t;

  // y*160 + x without a multiplier: 160 = 128 + 32.
  function automatic logic [ADDR_W-1:0] pixel_addr(input logic [Y_W-1:0] y,
                                                   input logic [X_W-1:0] x);
    logic [ADDR_W-1:0] y_ext;
    logic [ADDR_W-1:0] x_ext;
    y_ext = {{(ADDR_W-Y_W){1'b0}}, y};
    x_ext = {{(ADDR_W-X_W){1'b0}}, x};
    return (y_ext << 7) + (y_ext << 5) + x_ext;
  endfunction

endpackage

// File: rtl/pixel_write_sink_if.sv
// Pixel-write bus between a drawing block (master) and the framebuffer sink (slave).
interface pixel_write_sink_if;
  import pixel_write_sink_pkg::*;

  logic [X_W-1:0]      vga_x;
  logic [Y_W-1:0]      vga_y;
  logic [COLOUR_W-1:0] vga_colour;
  logic                vga_write;
  logic                ready;
  logic                dropped;

  modport master (
    output vga_x,
    output vga_y,
    output vga_colour,
    output vga_write,
    input  ready,
    input  dropped
  );

  modport slave (
    input  vga_x,
    input  vga_y,
    input  vga_colour,
    input  vga_write,
    output ready,
    output dropped
  );

endinterface

// File: rtl/pixel_fifo.sv
// Synchronous circular-buffer FIFO with occupancy count; head is visible on rdata while non-empty.
module pixel_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the count alone decides what is valid.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/pixel_write_sink.sv
// Buffers pixel writes, maps (x,y) to a linear framebuffer address and runs full-screen clears.
module pixel_write_sink #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned SCREEN_W   = pixel_write_sink_pkg::SCREEN_W,
    parameter int unsigned SCREEN_H   = pixel_write_sink_pkg::SCREEN_H
) (
    input  logic                                     clock,
    input  logic                                     reset,
    pixel_write_sink_if.slave                        pix,
    input  logic                                     start,
    input  logic [pixel_write_sink_pkg::COLOUR_W-1:0] clear_colour,
    output logic                                     done,
    output logic [pixel_write_sink_pkg::ADDR_W-1:0]   fb_address,
    output logic [pixel_write_sink_pkg::COLOUR_W-1:0] fb_data,
    output logic                                     fb_wren
);

  import pixel_write_sink_pkg::*;

  localparam int unsigned LastAddr = SCREEN_W * SCREEN_H - 1;

  state_e              state_q;
  logic [ADDR_W-1:0]   clr_cnt_q;
  logic [COLOUR_W-1:0] clr_colour_q;
  logic                dropped_q;
  logic                done_q;
  logic [ADDR_W-1:0]   fb_address_q;
  logic [COLOUR_W-1:0] fb_data_q;
  logic                fb_wren_q;

  logic   fifo_full;
  logic   fifo_empty;
  logic   accept;
  logic   in_range;
  logic   push;
  logic   pop;
  pixel_t push_entry;
  pixel_t head;

  assign pix.ready   = (state_q == StIdle) && !fifo_full;
  assign pix.dropped = dropped_q;
  assign done        = done_q;
  assign fb_address  = fb_address_q;
  assign fb_data     = fb_data_q;
  assign fb_wren     = fb_wren_q;

  assign accept   = pix.vga_write && pix.ready;
  assign in_range = (32'(pix.vga_x) < SCREEN_W) && (32'(pix.vga_y) < SCREEN_H);
  assign push     = accept && in_range;
  assign pop      = ((state_q == StIdle) || (state_q == StDrain)) && !fifo_empty;

  assign push_entry = '{addr: pixel_addr(pix.vga_y, pix.vga_x), colour: pix.vga_colour};

  pixel_fifo #(
    .WIDTH ($bits(pixel_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (push_entry),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      clr_cnt_q    <= '0;
      clr_colour_q <= '0;
      dropped_q    <= 1'b0;
      done_q       <= 1'b0;
      fb_address_q <= '0;
      fb_data_q    <= '0;
      fb_wren_q    <= 1'b0;
    end else begin
      dropped_q <= accept && !in_range;
      done_q    <= 1'b0;
      fb_wren_q <= 1'b0;

      if (pop) begin
        fb_address_q <= head.addr;
        fb_data_q    <= head.colour;
        fb_wren_q    <= 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (start) begin
            clr_colour_q <= clear_colour;
            state_q      <= StDrain;
          end
        end
        StDrain: begin
          // Pending pixels land first so the clear overwrites them deterministically.
          if (fifo_empty) begin
            clr_cnt_q <= '0;
            state_q   <= StClear;
          end
        end
        StClear: begin
          fb_address_q <= clr_cnt_q;
          fb_data_q    <= clr_colour_q;
          fb_wren_q    <= 1'b1;
          clr_cnt_q    <= clr_cnt_q + ADDR_W'(1);
          if (clr_cnt_q == ADDR_W'(LastAddr)) begin
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: doc/pixel_write_sink.md
Name: pixel_write_sink

Overview:
- Receiving end of the pixel-write interface driven by the drawing blocks: vga_x, vga_y, vga_colour, vga_write.
- Buffers accepted pixel writes in a small FIFO and converts (x,y) to a linear framebuffer address.
- Drives the framebuffer RAM write port at one write per cycle.
- Provides a start/done full-screen clear command used between frames.

Parameters:
- FIFO_DEPTH, 4, number of buffered pixel writes; power of 2, >= 2.
- SCREEN_W, 160, pixels per row.
- SCREEN_H, 120, rows.

Ports:
- clock  input  1  global clock.
- reset  input  1  asynchronous, active-low reset.
- vga_x  input  8  pixel column.
- vga_y  input  7  pixel row.
- vga_colour  input  18  pixel colour, 6 bits per channel.
- vga_write  input  1  write request, sampled on the rising clock edge.
- ready  output  1  sink accepts a write this cycle.
- dropped  output  1  one-cycle pulse when an accepted write is out of range.
- start  input  1  clear-screen request.
- clear_colour  input  18  fill colour, sampled with start.
- done  output  1  one-cycle pulse when the clear completes.
- fb_address  output  15  framebuffer word address.
- fb_data  output  18  framebuffer write data.
- fb_wren  output  1  framebuffer write enable.

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO emptied, state=IDLE, clear counter=0.
  - fb_wren=0, fb_address=0, fb_data=0, dropped=0, done=0.
  - ready=1 once reset deasserts.
- ready is combinational: (state==IDLE) && !fifo_full.
  - A write is accepted on an edge where vga_write && ready.
  - vga_write while ready=0 is ignored and lost; the producer must check ready.
  - No push-while-full, even if a pop occurs the same cycle.
- Range check at acceptance:
  - x >= SCREEN_W or y >= SCREEN_H: not enqueued; dropped=1 in the next cycle.
  - Otherwise push {address, colour}, with address = y*160 + x computed as (y<<7)+(y<<5)+x, 15 bits, max 19199.
- Drain:
  - In IDLE or DRAIN, if the FIFO is non-empty, pop the head each edge.
  - Register it onto fb_address/fb_data with fb_wren=1 for one cycle; otherwise fb_wren=0.
  - Latency: write sampled at edge k into an empty FIFO -> fb_wren high during the cycle after edge k+1.
  - Throughput: one pixel per cycle. Writes are committed in acceptance order.
- FIFO: circular buffer with wrapping read/write pointers plus an occupancy count (0..FIFO_DEPTH).
  - Full: count==FIFO_DEPTH. Empty: count==0.
  - Simultaneous push and pop leaves count unchanged.
- State machine:
  - IDLE: start=1 -> latch clear_colour -> DRAIN.
  - DRAIN: ready=0; FIFO empty -> CLEAR with counter=0.
  - CLEAR: each cycle fb_address=counter, fb_data=latched colour, fb_wren=1; counter increments. After writing address 19199 -> DONE.
  - DONE: done=1 for exactly one cycle -> IDLE.
- start is ignored outside IDLE.
- A clear takes 19200 write cycles plus drain time plus 1 cycle.
- Reset mid-clear or mid-drain: immediate return to IDLE; FIFO contents discarded; no done pulse.

Decomposition:
- Shared package (screen constants): SCREEN_W=160, SCREEN_H=120, FB_WORDS=19200, address width 15, colour width 18, state encodings IDLE/DRAIN/CLEAR/DONE.
- One natural sub-module: pixel_fifo, a parameterised synchronous FIFO with push/pop/full/empty and an asynchronous active-low reset.

Test Plan:
- Reset with a partially filled FIFO -> fb_wren=0, ready=1, done=0; no further writes emitted.
- Single write x=5, y=3, colour=18'h3F000, FIFO empty -> one fb_wren pulse 2 edges later, fb_address=485, fb_data=18'h3F000.
- Six back-to-back writes with FIFO_DEPTH=4 and the drain active -> ready stays 1; all six emerge in order, one per cycle.
  - Repeat with the drain slowed by an injected 5th-cycle stall -> ready=0 at full; the write presented while ready=0 is not emitted.
- Write x=160, y=0, and write x=0, y=120 -> no fb_wren; dropped pulses once for each.
- Queue 3 writes, then start with clear_colour=18'h00FFF -> the 3 writes are emitted first, then 19200 writes at addresses 0..19199 with data 18'h00FFF; done pulses once; ready=0 throughout.
- Assert reset at clear address 1000 -> fb_wren=0 immediately, no done pulse; a new start afterwards clears from address 0.
